// File: rtl/rom_axi_slave.sv
// ---------------------------------------------------------------------------
// rom_axi_slave
//
// Purpose:
//   Read-only AXI slave in front of a synchronous ROM. It handles one read
//   transaction at a time (INCR bursts of 32-bit beats) and steps the ROM
//   through consecutive word addresses. Each beat takes two cycles: one ROM
//   access cycle (READ), then one or more data cycles (DATA) that last until
//   the master accepts the beat. Bursts that are not INCR, or whose beats are
//   not 4 bytes wide, are still played out for the full length. Those beats
//   return SLVERR with zero data. There are no write channels.
//
// Parameters:
//   ID_BITS        AXI ID width
//   ROM_ADDR_BITS  ROM word-address width
//   DATA_BITS      AXI / ROM data width
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   ARID..ARVALID       AXI read address channel inputs
//   ARREADY             address accept (registered)
//   RID, RDATA, RRESP,
//   RLAST, RVALID       AXI read data channel outputs
//   RREADY              master ready for read data
//   ROM_enable,
//   ROM_read,
//   ROM_address         ROM control and word address (registered)
//   ROM_out             ROM data, valid one cycle after enable+read
// ---------------------------------------------------------------------------
module rom_axi_slave #(
  parameter int ID_BITS       = 8,
  parameter int ROM_ADDR_BITS = 14,
  parameter int DATA_BITS     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_BITS-1:0]       ARID,
  input  logic [31:0]              ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [ID_BITS-1:0]       RID,
  output logic [DATA_BITS-1:0]     RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic                     ROM_enable,
  output logic                     ROM_read,
  output logic [ROM_ADDR_BITS-1:0] ROM_address,
  input  logic [DATA_BITS-1:0]     ROM_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] len_q;
  logic [3:0] beat_q;
  logic       err_q;
  logic       burst_err;

  // The byte lane bits and the address bits above the ROM are not decoded.
  // The ROM simply wraps around, and an unaligned start address is rounded
  // down to its word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARADDR[31:ROM_ADDR_BITS+2], ARADDR[1:0]};

  // Only 4-byte INCR beats are supported. Any other combination is still
  // accepted and run for its full length, so the master sees a complete
  // burst, but every beat of it reports SLVERR.
  assign burst_err = (ARBURST != 2'b01) || (ARSIZE != 3'b010);

  // Read data is taken straight from the ROM while a beat is presented.
  // The ROM address and strobes stay put during DATA, so ROM_out, and with
  // it RDATA, remains stable under backpressure. Error beats are masked to
  // zero so no ROM contents leak out with an SLVERR.
  assign RDATA = (state == DATA && !err_q) ? ROM_out : '0;

  // Main FSM. All control outputs are registered here.
  // ARREADY only comes up on the first edge in IDLE. That keeps it low
  // straight out of reset and low while a burst is in flight. When a burst
  // finishes, it is raised on the same edge that returns to IDLE, so the
  // next address can be taken on the following cycle.
  // ROM_enable and ROM_read stay high from the address handshake until the
  // last beat is accepted. ROM_address only moves on a data handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ARREADY     <= 1'b0;
      RVALID      <= 1'b0;
      RLAST       <= 1'b0;
      RRESP       <= 2'b00;
      RID         <= '0;
      ROM_enable  <= 1'b0;
      ROM_read    <= 1'b0;
      ROM_address <= '0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ARVALID && ARREADY) begin
            RID         <= ARID;
            len_q       <= ARLEN;
            ROM_address <= ARADDR[ROM_ADDR_BITS+1:2];
            err_q       <= burst_err;
            RRESP       <= burst_err ? 2'b10 : 2'b00;
            beat_q      <= 4'd0;
            ARREADY     <= 1'b0;
            ROM_enable  <= 1'b1;
            ROM_read    <= 1'b1;
            state       <= READ;
          end else begin
            ARREADY <= 1'b1;
          end
        end

        READ: begin
          RVALID <= 1'b1;
          RLAST  <= (beat_q == len_q);
          state  <= DATA;
        end

        DATA: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            if (RLAST) begin
              ROM_enable <= 1'b0;
              ROM_read   <= 1'b0;
              ARREADY    <= 1'b1;
              state      <= IDLE;
            end else begin
              beat_q      <= beat_q + 4'd1;
              ROM_address <= ROM_address + ROM_ADDR_BITS'(1);
              state       <= READ;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_axi_slave.md
ROM_AXI_SLAVE -- requirements
Module: rom_axi_slave

Interface
REQ-001 Parameter ID_BITS, default 8, AXI ID width seen at slave side.
REQ-002 Parameter ROM_ADDR_BITS, default 14, ROM word-address width.
REQ-003 Parameter DATA_BITS, default 32, AXI/ROM data width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ARID  in  ID_BITS  read transaction ID.
REQ-007 ARADDR  in  32  byte start address.
REQ-008 ARLEN  in  4  beats minus one.
REQ-009 ARSIZE  in  3  beat size.
REQ-010 ARBURST  in  2  burst type.
REQ-011 ARVALID  in  1  address valid.
REQ-012 ARREADY  out  1  address accept.
REQ-013 RID  out  ID_BITS  returned ID.
REQ-014 RDATA  out  DATA_BITS  read data.
REQ-015 RRESP  out  2  response, 2'b00 OKAY, 2'b10 SLVERR.
REQ-016 RLAST  out  1  final beat.
REQ-017 RVALID  out  1  data valid.
REQ-018 RREADY  in  1  master accepts data.
REQ-019 ROM_enable  out  1  ROM chip enable.
REQ-020 ROM_read  out  1  ROM read strobe.
REQ-021 ROM_address  out  ROM_ADDR_BITS  ROM word address.
REQ-022 ROM_out  in  DATA_BITS  ROM data, valid one cycle after enable+read with stable address.

Function
REQ-023 FSM states IDLE, READ, DATA; one outstanding transaction; no write channels.
REQ-024 IDLE: ARREADY=1; on ARVALID&ARREADY latch ARID, ARLEN, word address ARADDR[ROM_ADDR_BITS+1:2], error flag; clear beat counter; go READ.
REQ-025 Error flag set when ARBURST!=2'b01 (INCR) or ARSIZE!=3'b010; ARADDR[1:0] ignored.
REQ-026 READ (exactly one cycle): ROM_enable=1, ROM_read=1, ROM_address=latched address, ARREADY=0; go DATA.
REQ-027 DATA: RVALID=1, ROM_enable/ROM_read stay 1 and ROM_address held, RDATA=ROM_out (0 when error flag), RID=latched ID, RRESP=2'b10 if error else 2'b00, RLAST=(beat counter==latched ARLEN).
REQ-028 DATA with RREADY=0: stay in DATA, all R outputs stable.
REQ-029 DATA with RREADY=1, RLAST=0: beat counter+1, address+1 modulo 2^ROM_ADDR_BITS, go READ.
REQ-030 DATA with RREADY=1, RLAST=1: go IDLE; ARREADY=1 next cycle.
REQ-031 Latency: AR handshake at edge T -> ROM enable cycle T+1 -> RVALID from T+2; each later beat 2 cycles after previous R handshake.
REQ-032 ARVALID ignored outside IDLE; ROM_enable, ROM_read, RVALID, RLAST all 0 in IDLE.
REQ-033 ARLEN=0: single beat, RLAST=1 on first RVALID.
REQ-034 Address wrap at top of ROM continues at word 0, no error.

Reset
REQ-035 rst=1 asynchronously forces IDLE, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, ROM_enable=0, ROM_read=0, ROM_address=0, counters/latches 0.
REQ-036 ARREADY rises on first clk edge after rst deasserts.
REQ-037 rst mid-burst abandons transaction; no further R beats issued.

Verification
REQ-038 Single: ARADDR=0x0000_0010, ARLEN=0, ARID=0x15, ROM[4]=0xDEADBEEF, RREADY=1 -> one beat at T+2, RDATA=0xDEADBEEF, RID=0x15, RLAST=1, RRESP=0.
REQ-039 Burst: ARADDR=0x100, ARLEN=3 -> ROM_address 0x40..0x43 in order, 4 beats, RLAST only on 4th, ARREADY=1 cycle after.
REQ-040 Backpressure: RREADY=0 for 5 cycles on beat 2 -> RVALID, RDATA, RLAST held stable; no address advance.
REQ-041 Error: ARBURST=2'b00, ARLEN=1 -> 2 beats, RRESP=2'b10, RDATA=0.
REQ-042 Wrap: ARADDR=0xFFFC (word 0x3FFF), ARLEN=1 -> ROM_address 0x3FFF then 0x0000.
REQ-043 Reset mid-burst after beat 1 of ARLEN=7 -> all outputs 0 immediately, ARREADY=1 one edge after release, no stray RVALID.
